// File: rtl/rs_alloc_ctrl.sv
// Reservation-station allocation controller: tracks busy entries and speculative
// tags, grants up to two lowest free entries per cycle, frees on issue, kills on mispredict.
module rs_alloc_ctrl #(
    parameter int ENT_NUM     = 8,
    parameter int ENT_SEL     = 3,
    parameter int SPECTAG_LEN = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             reqnum,
    input  logic                   dispatch_go,
    input  logic [SPECTAG_LEN-1:0] alloc_spectag1,
    input  logic [SPECTAG_LEN-1:0] alloc_spectag2,
    output logic                   alloc_ok,
    output logic [ENT_SEL-1:0]     alloc_ent1,
    output logic [ENT_SEL-1:0]     alloc_ent2,
    input  logic                   issue_valid,
    input  logic [ENT_SEL-1:0]     issue_ent,
    input  logic                   prmiss,
    input  logic [SPECTAG_LEN-1:0] kill_mask,
    input  logic                   prsuccess,
    input  logic [SPECTAG_LEN-1:0] succ_mask,
    output logic [ENT_NUM-1:0]     busy_vec,
    output logic [ENT_SEL:0]       free_cnt,
    output logic                   full,
    output logic                   recovering
);

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [ENT_NUM-1:0]       busy_q, busy_d;
    logic [SPECTAG_LEN-1:0]   tag_q [ENT_NUM];
    logic [SPECTAG_LEN-1:0]   tag_d [ENT_NUM];
    logic [ENT_SEL:0]         free_cnt_q, free_cnt_d;

    logic                     en1, en2;
    logic [ENT_SEL-1:0]       ent1, ent2;
    logic [1:0]               avail;
    logic                     alloc_fire;

    // Priority search over registered busy: entries freed this cycle are not visible yet.
    always_comb begin
        en1  = 1'b0;
        en2  = 1'b0;
        ent1 = '0;
        ent2 = '0;
        for (int i = 0; i < ENT_NUM; i++) begin
            if (!busy_q[i] && !en1) begin
                en1  = 1'b1;
                ent1 = ENT_SEL'(i);
            end
        end
        for (int i = 0; i < ENT_NUM; i++) begin
            if (!busy_q[i] && en1 && !en2 && (ENT_SEL'(i) > ent1)) begin
                en2  = 1'b1;
                ent2 = ENT_SEL'(i);
            end
        end
    end

    always_comb begin
        avail      = {1'b0, en1} + {1'b0, en2};
        alloc_ok   = (state_q == RUN) && !prmiss && (reqnum <= avail);
        alloc_fire = dispatch_go && alloc_ok && !prmiss;
        alloc_ent1 = ent1;
        alloc_ent2 = ent2;
    end

    always_comb begin
        state_d = prmiss ? RECOVER : RUN;
    end

    // Lowest priority applied first so later steps override: allocate, issue, kill.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < ENT_NUM; i++) begin
            tag_d[i] = tag_q[i];
        end
        if (alloc_fire && (reqnum != 2'd0)) begin
            busy_d[ent1] = 1'b1;
            tag_d[ent1]  = alloc_spectag1;
            if (reqnum == 2'd2) begin
                busy_d[ent2] = 1'b1;
                tag_d[ent2]  = alloc_spectag2;
            end
        end
        if (issue_valid) begin
            busy_d[issue_ent] = 1'b0;
        end
        if (prmiss) begin
            for (int i = 0; i < ENT_NUM; i++) begin
                if ((tag_q[i] & kill_mask) != '0) begin
                    busy_d[i] = 1'b0;
                end
            end
        end
        if (prsuccess) begin
            for (int i = 0; i < ENT_NUM; i++) begin
                tag_d[i] = tag_d[i] & ~succ_mask;
            end
        end
    end

    always_comb begin
        free_cnt_d = (ENT_SEL+1)'(ENT_NUM);
        for (int i = 0; i < ENT_NUM; i++) begin
            free_cnt_d = free_cnt_d - {{ENT_SEL{1'b0}}, busy_d[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            busy_q     <= '0;
            free_cnt_q <= (ENT_SEL+1)'(ENT_NUM);
            for (int i = 0; i < ENT_NUM; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            free_cnt_q <= free_cnt_d;
            for (int i = 0; i < ENT_NUM; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign busy_vec   = busy_q;
    assign free_cnt   = free_cnt_q;
    assign full       = (free_cnt_q == '0);
    assign recovering = (state_q == RECOVER);

endmodule

// File: tb/tb_rs_alloc_ctrl.sv
// Directed bench for rs_alloc_ctrl: fill, single-slot grant, kill, success, free issue, reset.
module tb_rs_alloc_ctrl;

    logic       clk, reset;
    logic [1:0] reqnum;
    logic       dispatch_go;
    logic [4:0] alloc_spectag1, alloc_spectag2;
    logic       alloc_ok;
    logic [2:0] alloc_ent1, alloc_ent2;
    logic       issue_valid;
    logic [2:0] issue_ent;
    logic       prmiss;
    logic [4:0] kill_mask;
    logic       prsuccess;
    logic [4:0] succ_mask;
    logic [7:0] busy_vec;
    logic [3:0] free_cnt;
    logic       full, recovering;

    int checks = 0;
    int errors = 0;

    rs_alloc_ctrl #(.ENT_NUM(8), .ENT_SEL(3), .SPECTAG_LEN(5)) dut (
        .clk(clk), .reset(reset), .reqnum(reqnum), .dispatch_go(dispatch_go),
        .alloc_spectag1(alloc_spectag1), .alloc_spectag2(alloc_spectag2),
        .alloc_ok(alloc_ok), .alloc_ent1(alloc_ent1), .alloc_ent2(alloc_ent2),
        .issue_valid(issue_valid), .issue_ent(issue_ent),
        .prmiss(prmiss), .kill_mask(kill_mask),
        .prsuccess(prsuccess), .succ_mask(succ_mask),
        .busy_vec(busy_vec), .free_cnt(free_cnt), .full(full), .recovering(recovering)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        reset = 0; reqnum = 0; dispatch_go = 0; alloc_spectag1 = 0; alloc_spectag2 = 0;
        issue_valid = 0; issue_ent = 0; prmiss = 0; kill_mask = 0; prsuccess = 0; succ_mask = 0;
    endtask

    // Advance past the next rising edge; inputs then change, and #1 later comb outputs settle.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        cyc(); cyc();
        reset = 0; reqnum = 2;
        #1;
        checks++; if (busy_vec !== 8'h00) begin errors++; $display("FAIL reset_busy got %h exp 00", busy_vec); end
        checks++; if (free_cnt !== 4'd8) begin errors++; $display("FAIL reset_free got %0d exp 8", free_cnt); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
        checks++; if (recovering !== 1'b0) begin errors++; $display("FAIL reset_recov got %b exp 0", recovering); end
        checks++; if (alloc_ok !== 1'b1) begin errors++; $display("FAIL reset_ok got %b exp 1", alloc_ok); end
        checks++; if (alloc_ent1 !== 3'd0) begin errors++; $display("FAIL reset_ent1 got %0d exp 0", alloc_ent1); end
        checks++; if (alloc_ent2 !== 3'd1) begin errors++; $display("FAIL reset_ent2 got %0d exp 1", alloc_ent2); end
    endtask

    task automatic test_fill();
        for (int k = 0; k < 4; k++) begin
            reqnum = 2; dispatch_go = 1;
            #1;
            checks++; if (alloc_ok !== 1'b1) begin errors++; $display("FAIL fill_ok[%0d] got %b exp 1", k, alloc_ok); end
            checks++; if (alloc_ent1 !== 3'(2*k)) begin errors++; $display("FAIL fill_ent1[%0d] got %0d exp %0d", k, alloc_ent1, 2*k); end
            checks++; if (alloc_ent2 !== 3'(2*k+1)) begin errors++; $display("FAIL fill_ent2[%0d] got %0d exp %0d", k, alloc_ent2, 2*k+1); end
            cyc();
        end
        dispatch_go = 0; reqnum = 1;
        #1;
        checks++; if (busy_vec !== 8'hFF) begin errors++; $display("FAIL fill_busy got %h exp ff", busy_vec); end
        checks++; if (free_cnt !== 4'd0) begin errors++; $display("FAIL fill_free got %0d exp 0", free_cnt); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", full); end
        checks++; if (alloc_ok !== 1'b0) begin errors++; $display("FAIL fill_ok_full got %b exp 0", alloc_ok); end
    endtask

    task automatic test_single_free();
        reqnum = 0; issue_valid = 1; issue_ent = 4;
        cyc();
        issue_valid = 0; reqnum = 2;
        #1;
        checks++; if (busy_vec !== 8'hEF) begin errors++; $display("FAIL single_busy got %h exp ef", busy_vec); end
        checks++; if (free_cnt !== 4'd1) begin errors++; $display("FAIL single_free got %0d exp 1", free_cnt); end
        checks++; if (alloc_ok !== 1'b0) begin errors++; $display("FAIL single_ok_req2 got %b exp 0", alloc_ok); end
        reqnum = 1; dispatch_go = 1; issue_valid = 1; issue_ent = 2;
        #1;
        checks++; if (alloc_ok !== 1'b1) begin errors++; $display("FAIL single_ok_req1 got %b exp 1", alloc_ok); end
        checks++; if (alloc_ent1 !== 3'd4) begin errors++; $display("FAIL single_ent1 got %0d exp 4", alloc_ent1); end
        checks++; if (alloc_ent2 !== 3'd0) begin errors++; $display("FAIL single_ent2 got %0d exp 0", alloc_ent2); end
        cyc();
        idle();
        #1;
        checks++; if (busy_vec !== 8'hFB) begin errors++; $display("FAIL single_issue_busy got %h exp fb", busy_vec); end
        checks++; if (free_cnt !== 4'd1) begin errors++; $display("FAIL single_issue_free got %0d exp 1", free_cnt); end
    endtask

    task automatic test_issue_free();
        issue_valid = 1; issue_ent = 2;
        cyc();
        idle();
        #1;
        checks++; if (busy_vec !== 8'hFB) begin errors++; $display("FAIL issue_free_busy got %h exp fb", busy_vec); end
        checks++; if (free_cnt !== 4'd1) begin errors++; $display("FAIL issue_free_cnt got %0d exp 1", free_cnt); end
    endtask

    task automatic test_kill();
        idle();
        reset = 1;
        cyc();
        reset = 0; reqnum = 2; dispatch_go = 1; alloc_spectag1 = 5'b00001; alloc_spectag2 = 5'b00010;
        cyc();
        alloc_spectag1 = 5'b00100; alloc_spectag2 = 5'b00010;
        cyc();
        reqnum = 1; dispatch_go = 1; prmiss = 1; kill_mask = 5'b00010; alloc_spectag1 = 5'b00001;
        #1;
        checks++; if (busy_vec !== 8'h0F) begin errors++; $display("FAIL kill_pre_busy got %h exp 0f", busy_vec); end
        checks++; if (alloc_ok !== 1'b0) begin errors++; $display("FAIL kill_ok_c0 got %b exp 0", alloc_ok); end
        checks++; if (recovering !== 1'b0) begin errors++; $display("FAIL kill_recov_c0 got %b exp 0", recovering); end
        cyc();
        prmiss = 0; kill_mask = 0;
        #1;
        checks++; if (busy_vec !== 8'h05) begin errors++; $display("FAIL kill_busy got %h exp 05", busy_vec); end
        checks++; if (free_cnt !== 4'd6) begin errors++; $display("FAIL kill_free got %0d exp 6", free_cnt); end
        checks++; if (recovering !== 1'b1) begin errors++; $display("FAIL kill_recov_c1 got %b exp 1", recovering); end
        checks++; if (alloc_ok !== 1'b0) begin errors++; $display("FAIL kill_ok_c1 got %b exp 0", alloc_ok); end
        cyc();
        dispatch_go = 0;
        #1;
        checks++; if (recovering !== 1'b0) begin errors++; $display("FAIL kill_recov_c2 got %b exp 0", recovering); end
        checks++; if (alloc_ok !== 1'b1) begin errors++; $display("FAIL kill_ok_c2 got %b exp 1", alloc_ok); end
        checks++; if (busy_vec !== 8'h05) begin errors++; $display("FAIL kill_noalloc_busy got %h exp 05", busy_vec); end
        checks++; if (alloc_ent1 !== 3'd1) begin errors++; $display("FAIL kill_ent1 got %0d exp 1", alloc_ent1); end
        checks++; if (alloc_ent2 !== 3'd3) begin errors++; $display("FAIL kill_ent2 got %0d exp 3", alloc_ent2); end
    endtask

    task automatic test_success();
        // Entries 1 and 3 allocated in the same cycle as the success clearing bit 1.
        reqnum = 2; dispatch_go = 1; alloc_spectag1 = 5'b00010; alloc_spectag2 = 5'b00011;
        prsuccess = 1; succ_mask = 5'b00010;
        cyc();
        idle();
        prmiss = 1; kill_mask = 5'b00010;
        #1;
        checks++; if (busy_vec !== 8'h0F) begin errors++; $display("FAIL succ_alloc_busy got %h exp 0f", busy_vec); end
        cyc();
        kill_mask = 5'b00001;
        #1;
        checks++; if (busy_vec !== 8'h0F) begin errors++; $display("FAIL succ_nokill_busy got %h exp 0f", busy_vec); end
        checks++; if (recovering !== 1'b1) begin errors++; $display("FAIL succ_recov_a got %b exp 1", recovering); end
        cyc();
        idle();
        #1;
        checks++; if (recovering !== 1'b1) begin errors++; $display("FAIL succ_recov_hold got %b exp 1", recovering); end
        checks++; if (busy_vec !== 8'h06) begin errors++; $display("FAIL succ_kill2_busy got %h exp 06", busy_vec); end
        checks++; if (free_cnt !== 4'd6) begin errors++; $display("FAIL succ_kill2_free got %0d exp 6", free_cnt); end
        cyc();
        checks++; if (recovering !== 1'b0) begin errors++; $display("FAIL succ_recov_end got %b exp 0", recovering); end
    endtask

    task automatic test_reset_mid();
        reqnum = 2; dispatch_go = 1; alloc_spectag1 = 5'b00001; alloc_spectag2 = 5'b00001;
        cyc();
        reset = 1; prmiss = 1; kill_mask = 5'b00100; issue_valid = 1; issue_ent = 1;
        cyc();
        idle(); reqnum = 2;
        #1;
        checks++; if (busy_vec !== 8'h00) begin errors++; $display("FAIL mid_busy got %h exp 00", busy_vec); end
        checks++; if (free_cnt !== 4'd8) begin errors++; $display("FAIL mid_free got %0d exp 8", free_cnt); end
        checks++; if (recovering !== 1'b0) begin errors++; $display("FAIL mid_recov got %b exp 0", recovering); end
        checks++; if (alloc_ok !== 1'b1) begin errors++; $display("FAIL mid_ok got %b exp 1", alloc_ok); end
        checks++; if (alloc_ent1 !== 3'd0 || alloc_ent2 !== 3'd1) begin errors++; $display("FAIL mid_ents got %0d,%0d exp 0,1", alloc_ent1, alloc_ent2); end
    endtask

    initial begin
        idle();
        test_reset();
        test_fill();
        test_single_free();
        test_issue_free();
        test_kill();
        test_success();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
